scan_chain_ctrl: RTL
====================

# scan_chain_ctrl

Scan-test sequencer that sits directly upstream of a chain of scan flip-flops with an active-low reset. It drives the chain's SE, SI and clock-enable. It also consumes the chain's serial output SO. Test patterns arrive through a valid/ready port and are shifted in serially, then captured. Each captured response is compacted into a 16-bit serial MISR signature, which is reported once the last pattern's response has been flushed.

## Interface
- CHAIN_LEN, 32: number of flops in the driven chain; legal range 2..64.
- CNT_W, 6: shift-counter width; must satisfy 2^CNT_W >= CHAIN_LEN.
- CLK  input  1  sole clock; all state changes on the rising edge.
- RN  input  1  reset: one clock; reset is synchronous and active-low.
- pat_valid  input  1  pattern word offered.
- pat_ready  output  1  block can accept a pattern; high only in IDLE and WAIT.
- pat_data  input  CHAIN_LEN  pattern; bit k is destined for chain flop k, counted from the SI end.
- pat_last  input  1  qualifies pat_data as the final pattern of the test.
- SE  output  1  scan enable to the chain.
- SI  output  1  scan data to the first chain flop.
- CE  output  1  chain clock enable; the chain advances only on edges where CE=1.
- SO  input  1  Q of the last chain flop.
- busy  output  1  high in every state except IDLE.
- sig_valid  output  1  one-cycle pulse when sig is final.
- sig  output  16  MISR signature; holds its value after DONE.
- pat_cnt  output  16  patterns accepted since the last test start; saturates at 16'hFFFF.

## Operation
- States: IDLE, SHIFT, CAPTURE, WAIT, FLUSH, DONE.
- Accept: a pattern is accepted on the edge where pat_valid & pat_ready.
  - On acceptance, load the shift register with pat_data and latch pat_last.
  - Clear the shift counter to 0 and go to SHIFT.
- Acceptance from IDLE starts a new test:
  - clear sig to 0 and clear the have_cap flag;
  - set pat_cnt to 1.
- Acceptance from WAIT increments pat_cnt, saturating at 16'hFFFF.
- SHIFT (CHAIN_LEN cycles):
  - SE=1, CE=1, SI=shreg[CHAIN_LEN-1], with the register shifting left every cycle.
  - pat_data[CHAIN_LEN-1] therefore goes out first and pat_data[0] last.
  - When counter == CHAIN_LEN-1, go to CAPTURE; otherwise increment the counter.
- CAPTURE (1 cycle): SE=0, CE=1, SI=0. Set have_cap=1.
  - If the latched last flag is set, go to FLUSH with the counter at 0; otherwise go to WAIT.
- WAIT: SE=0, CE=0, pat_ready=1. Stay until a pattern is accepted; the chain holds its state.
- FLUSH (CHAIN_LEN cycles): SE=1, CE=1, SI=0. Go to DONE after CHAIN_LEN cycles.
- DONE (1 cycle): sig_valid=1, then go to IDLE.
- MISR update runs on every SHIFT or FLUSH edge where have_cap=1:
  - fb = sig[15]^SO;
  - sig <= {sig[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0000).
- MISR gating: while have_cap=0, SO is ignored, because the first shift unloads post-reset chain contents.
- pat_valid and pat_data are ignored whenever pat_ready=0.
- pat_last on the first pattern is legal: the test is then shift, capture, flush, done.

## Timing
- Reset (RN=0 at an edge), in any state: state IDLE; SE=0, SI=0, CE=0, busy=0, sig_valid=0, sig=0, pat_cnt=0, have_cap=0.
- Reset mid-SHIFT or mid-FLUSH aborts without a sig_valid pulse.
- All outputs are registered except pat_ready and busy, which are decoded from state only.
- Acceptance edge at cycle t:
  - SE=CE=1 with SI=pat_data[CHAIN_LEN-1] from cycle t+1 through t+CHAIN_LEN;
  - CAPTURE at cycle t+CHAIN_LEN+1;
  - earliest next acceptance edge is at the end of cycle t+CHAIN_LEN+2, the first WAIT cycle.
- Per-pattern period with pat_valid held high: CHAIN_LEN+2 cycles.
- Last-pattern acceptance at cycle t:
  - FLUSH from t+CHAIN_LEN+2 to t+2*CHAIN_LEN+1;
  - sig_valid at t+2*CHAIN_LEN+2;
  - pat_ready high again at t+2*CHAIN_LEN+3.
- SO is sampled on the same edge that shifts the chain. Response bit j is the SO value present during shift cycle j, and chain flop CHAIN_LEN-1 comes out first.

## Test plan
- Reset checks: hold RN=0 for 3 edges during SHIFT with CHAIN_LEN=8.
  - Required: every output is at its reset value on the next cycle.
  - Required: no sig_valid pulse occurs.
- Single pattern, CHAIN_LEN=8: pat_data=8'hA5 with pat_last=1, chain model is 8 ideal scan flops with D tied to ~Q.
  - Required: SI sequence is 1,0,1,0,0,1,0,1 and SE drops for exactly one cycle.
  - Required: MISR input is the 8 SO bits of the capture 8'h5A.
  - Required: sig equals the software MISR of those bits, and sig_valid pulses at acceptance+18.
- Back-to-back patterns: 3 patterns with pat_valid held high.
  - Required: acceptances are 10 cycles apart.
  - Required: pat_cnt reads 1, 2, 3 and pattern 1's shift-in does not feed the MISR.
- WAIT stall: hold pat_valid low for 20 cycles between patterns.
  - Required: CE=0 throughout the stall, the chain model is unchanged, and sig is identical to the no-stall run.
- Ignore when not ready: toggle pat_valid with junk data during SHIFT.
  - Required: no acceptance, and pat_cnt and the shift register are unaffected.
- pat_cnt saturation: force pat_cnt to 16'hFFFE and accept 3 more patterns.
  - Required: pat_cnt reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// Scan-test sequencer: shifts patterns into a scan chain, captures, and folds
// the unloaded responses into a 16-bit serial MISR signature.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = 6
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic                 pat_last,
  output logic                 SE,
  output logic                 SI,
  output logic                 CE,
  input  logic                 SO,
  output logic                 busy,
  output logic                 sig_valid,
  output logic [15:0]          sig,
  output logic [15:0]          pat_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    WAIT    = 3'd3,
    FLUSH   = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state;
  logic [CHAIN_LEN-1:0] shreg;
  logic [CNT_W-1:0]     cnt;
  logic                 last_q;
  logic                 have_cap;
  logic                 accept;

  function automatic logic [15:0] misr_next(input logic [15:0] s, input logic so);
    logic fb;
    fb = s[15] ^ so;
    return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign pat_ready = (state == IDLE) || (state == WAIT);
  assign busy      = (state != IDLE);
  assign accept    = pat_valid & pat_ready;

  // shreg[CHAIN_LEN-1] always mirrors the bit currently presented on SI
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state     <= IDLE;
      SE        <= 1'b0;
      SI        <= 1'b0;
      CE        <= 1'b0;
      sig_valid <= 1'b0;
      sig       <= 16'h0000;
      pat_cnt   <= 16'h0000;
      have_cap  <= 1'b0;
    end else begin
      sig_valid <= 1'b0;
      case (state)
        IDLE, WAIT: begin
          if (accept) begin
            shreg  <= pat_data;
            last_q <= pat_last;
            cnt    <= '0;
            state  <= SHIFT;
            SE     <= 1'b1;
            CE     <= 1'b1;
            SI     <= pat_data[CHAIN_LEN-1];
            if (state == IDLE) begin
              sig      <= 16'h0000;
              have_cap <= 1'b0;
              pat_cnt  <= 16'd1;
            end else begin
              pat_cnt  <= sat_inc(pat_cnt);
            end
          end
        end
        SHIFT: begin
          // the first shift of a test unloads stale chain contents, so it is not compacted
          if (have_cap) sig <= misr_next(sig, SO);
          shreg <= {shreg[CHAIN_LEN-2:0], 1'b0};
          if (cnt == CNT_LAST) begin
            state <= CAPTURE;
            SE    <= 1'b0;
            CE    <= 1'b1;
            SI    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            SI  <= shreg[CHAIN_LEN-2];
          end
        end
        CAPTURE: begin
          have_cap <= 1'b1;
          cnt      <= '0;
          SI       <= 1'b0;
          if (last_q) begin
            state <= FLUSH;
            SE    <= 1'b1;
            CE    <= 1'b1;
          end else begin
            state <= WAIT;
            SE    <= 1'b0;
            CE    <= 1'b0;
          end
        end
        FLUSH: begin
          if (have_cap) sig <= misr_next(sig, SO);
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            SE        <= 1'b0;
            CE        <= 1'b0;
            sig_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
